// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the RAM request front-end.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Pointer width for a power-of-two buffer depth.
    function automatic int rsp_clog2(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_req_ctrl_rsp_fifo.sv
// Synchronous FIFO holding read responses until the consumer takes them.
module rsp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = rsp_clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [PTR_W:0]    count,
    output logic              empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Front-end for the single-port sync RAM: post-reset/on-demand clear sweep,
// request pass-through onto the RAM pins and an ordered read-response buffer.
//
// state | meaning
// BOOT  | one idle cycle after reset so mem_we stays low
// CLEAR | writing INIT_VAL to addresses 0..DEPTH-1
// RUN   | servicing read/write requests
// DRAIN | clear requested; waiting for outstanding reads to be consumed
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0,
    parameter int                RSP_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clr_req,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int              CNT_W     = rsp_clog2(RSP_DEPTH) + 1;
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [CNT_W:0]  RSP_LIM   = (CNT_W + 1)'(RSP_DEPTH);

    ctrl_state_t       state;
    logic [ADDR_W:0]   clr_cnt;
    logic              inflight;
    logic              clr_pend;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              rd_room;
    logic              run_ready;
    logic              accept_rd;

    // Buffered plus in-RAM reads: both registered, so no path from rsp_ready.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign rd_room   = occupancy < RSP_LIM;
    assign run_ready = (state == RUN) && !clr_pend && (req_we || rd_room);
    assign req_ready = run_ready;
    assign accept_rd = req_valid && run_ready && !req_we;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = req_addr;
        mem_d    = req_wdata;
        case (state)
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_cnt[ADDR_W-1:0];
                mem_d    = INIT_VAL;
            end
            RUN:     mem_we = req_valid && run_ready && req_we;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state     <= BOOT;
            clr_cnt   <= '0;
            inflight  <= 1'b0;
            clr_pend  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            inflight <= accept_rd;
            case (state)
                BOOT: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        clr_pend  <= 1'b1;
                        init_done <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight && fifo_empty) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        clr_pend <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // RAM Q reflects the address accepted last cycle; capture it then.
    rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK   (CLK),
        .RST_X (RST_X),
        .push  (inflight),
        .din   (mem_q),
        .pop   (rsp_ready),
        .dout  (rsp_data),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;

endmodule
